// File: rtl/reorder_buffer_mw.sv
// Multi-wide reorder buffer: in-order dispatch, out-of-order writeback,
// in-order commit with mispredict redirect and full flush.
module reorder_buffer_mw #(
  parameter int NUM_ENTRY  = 32,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 4,
  parameter int PAYLOAD_W  = 64,
  parameter int IDX_W      = $clog2(NUM_ENTRY)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [DISPATCH_W-1:0]           disp_valid,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  output logic                            disp_ready,
  output logic [DISPATCH_W*IDX_W-1:0]     disp_id,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]       wb_id,
  input  logic [WB_PORTS-1:0]             wb_mispredict,
  output logic [COMMIT_W-1:0]             commit_valid,
  output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload,
  output logic [COMMIT_W*IDX_W-1:0]       commit_id,
  output logic [COMMIT_W-1:0]             commit_mispredict,
  output logic                            redirect,
  output logic [IDX_W:0]                  occupancy,
  output logic                            empty
);

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  ptr_t head_q, tail_q, head_d, tail_d;
  ptr_t n_disp, n_com;
  logic [NUM_ENTRY-1:0] done_q, done_d, misp_q, misp_d;
  logic [PAYLOAD_W-1:0] mem [NUM_ENTRY];
  idx_t cidx [COMMIT_W];
  idx_t woff [WB_PORTS];
  logic [WB_PORTS-1:0] wb_hit;
  logic disp_go, run, ok;

  always_comb begin
    occupancy  = tail_q - head_q;
    empty      = (occupancy == '0);
    disp_ready = (ptr_t'(NUM_ENTRY) - occupancy) >= ptr_t'(DISPATCH_W);
    n_disp = '0;
    run    = 1'b1;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_id[k*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + idx_t'(k);
      run = run & disp_valid[k];
      if (run) n_disp = n_disp + ptr_t'(1);
    end
  end

  // Commit stops after the first not-done entry or the first mispredict
  always_comb begin
    ok       = 1'b1;
    n_com    = '0;
    redirect = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cidx[k] = head_q[IDX_W-1:0] + idx_t'(k);
      commit_id[k*IDX_W +: IDX_W]         = cidx[k];
      commit_payload[k*PAYLOAD_W +: PAYLOAD_W] = mem[cidx[k]];
      commit_mispredict[k] = misp_q[cidx[k]];
      commit_valid[k] = ok && (ptr_t'(k) < occupancy) && done_q[cidx[k]];
      ok = commit_valid[k] && !misp_q[cidx[k]];
      if (commit_valid[k]) n_com = n_com + ptr_t'(1);
      if (commit_valid[k] && misp_q[cidx[k]]) redirect = 1'b1;
    end
  end

  always_comb begin
    done_d  = done_q;
    misp_d  = misp_q;
    head_d  = head_q;
    tail_d  = tail_q;
    disp_go = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      woff[p]   = wb_id[p*IDX_W +: IDX_W] - head_q[IDX_W-1:0];
      wb_hit[p] = wb_valid[p] && ({1'b0, woff[p]} < occupancy);
      if (wb_hit[p]) misp_d[wb_id[p*IDX_W +: IDX_W]] = 1'b0;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_hit[p]) begin
        done_d[wb_id[p*IDX_W +: IDX_W]] = 1'b1;
        misp_d[wb_id[p*IDX_W +: IDX_W]] =
          misp_d[wb_id[p*IDX_W +: IDX_W]] | wb_mispredict[p];
      end
    end
    for (int k = 0; k < COMMIT_W; k++)
      if (commit_valid[k]) done_d[cidx[k]] = 1'b0;
    head_d = head_q + n_com;
    if (redirect) begin
      tail_d = head_d;
      done_d = '0;
    end else if (disp_ready && n_disp != '0) begin
      disp_go = 1'b1;
      tail_d  = tail_q + n_disp;
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (ptr_t'(k) < n_disp) begin
          done_d[tail_q[IDX_W-1:0] + idx_t'(k)] = 1'b0;
          misp_d[tail_q[IDX_W-1:0] + idx_t'(k)] = 1'b0;
        end
      end
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      done_d  = '0;
      misp_d  = '0;
      disp_go = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
      misp_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
      misp_q <= misp_d;
    end
  end

  // Payload array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (disp_go) begin
      for (int k = 0; k < DISPATCH_W; k++)
        if (ptr_t'(k) < n_disp)
          mem[tail_q[IDX_W-1:0] + idx_t'(k)] <=
            disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Randomized bench for reorder_buffer_mw against a queue-based ROB model,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer_mw;

  localparam int NE = 32;
  localparam int IW = 5;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    disp_valid;
  logic [127:0]  disp_payload;
  logic          disp_ready;
  logic [9:0]    disp_id;
  logic [3:0]    wb_valid;
  logic [19:0]   wb_id;
  logic [3:0]    wb_mispredict;
  logic [1:0]    commit_valid;
  logic [127:0]  commit_payload;
  logic [9:0]    commit_id;
  logic [1:0]    commit_mispredict;
  logic          redirect;
  logic [5:0]    occupancy;
  logic          empty;

  reorder_buffer_mw dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .disp_id(disp_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_mispredict(wb_mispredict),
    .commit_valid(commit_valid), .commit_payload(commit_payload),
    .commit_id(commit_id), .commit_mispredict(commit_mispredict),
    .redirect(redirect), .occupancy(occupancy), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [63:0] pay;
    bit          done;
    bit          misp;
  } ent_t;

  ent_t rob[$];
  int   hptr = 0, tptr = 0;
  int   m_occ, m_c, m_n;
  bit   m_rd, m_stop, m_hit, m_m;
  ent_t e;

  // Model: the ROB is a queue of in-flight entries, oldest first
  always @(negedge clk) begin
    if (rst) begin
      rob.delete();
      hptr = 0;
      tptr = 0;
      chk("rst_occupancy", occupancy, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_redirect", redirect, 0);
    end else begin
      m_occ = rob.size();
      chk("occupancy", occupancy, m_occ);
      chk("empty", empty, m_occ == 0);
      chk("disp_ready", disp_ready, (NE - m_occ) >= 2);
      for (int k = 0; k < 2; k++)
        chk("disp_id", disp_id[k*IW +: IW], (tptr + k) % NE);
      m_c = 0; m_rd = 0; m_stop = 0;
      for (int k = 0; k < 2; k++) begin
        if (!m_stop && k < m_occ && rob[k].done) begin
          m_c++;
          if (rob[k].misp) begin m_rd = 1; m_stop = 1; end
        end else m_stop = 1;
      end
      chk("commit_valid", commit_valid, (m_c == 0) ? 0 : (m_c == 1) ? 1 : 3);
      chk("redirect", redirect, m_rd);
      for (int k = 0; k < m_c; k++) begin
        chk("commit_id", commit_id[k*IW +: IW], rob[k].id);
        chk("commit_payload", commit_payload[k*PW +: PW], rob[k].pay);
        chk("commit_mispredict", commit_mispredict[k], rob[k].misp);
      end
      for (int i = 0; i < rob.size(); i++) begin
        m_hit = 0; m_m = 0;
        for (int p = 0; p < 4; p++)
          if (wb_valid[p] && int'(wb_id[p*IW +: IW]) == rob[i].id) begin
            m_hit = 1;
            m_m = m_m | wb_mispredict[p];
          end
        if (m_hit) begin rob[i].done = 1; rob[i].misp = m_m; end
      end
      if (flush) begin
        rob.delete(); hptr = 0; tptr = 0;
      end else begin
        repeat (m_c) void'(rob.pop_front());
        hptr = (hptr + m_c) % NE;
        if (m_rd) begin
          rob.delete(); tptr = hptr;
        end else if ((NE - m_occ) >= 2) begin
          m_n = disp_valid[0] ? (disp_valid[1] ? 2 : 1) : 0;
          for (int k = 0; k < m_n; k++) begin
            e.id = (tptr + k) % NE;
            e.pay = disp_payload[k*PW +: PW];
            e.done = 0; e.misp = 0;
            rob.push_back(e);
          end
          tptr = (tptr + m_n) % NE;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0;
    disp_payload = {$urandom, $urandom, $urandom, $urandom};
    wb_valid = 0; wb_id = 0; wb_mispredict = 0;
  endtask

  task automatic wb(int p, int id, bit m);
    wb_valid[p] = 1'b1;
    wb_id[p*IW +: IW] = IW'(id);
    wb_mispredict[p] = m;
  endtask

  task automatic disp2();
    idle();
    disp_valid = 2'b11;
  endtask

  initial begin
    rst = 1; idle();
    repeat (2) tick();
    rst = 0;
    @(negedge clk);
    chk("reset_occ", occupancy, 0);
    chk("reset_empty", empty, 1);
    chk("reset_ready", disp_ready, 1);
    chk("reset_cv", commit_valid, 0);
    chk("reset_redirect", redirect, 0);
    tick();

    for (int i = 0; i < 16; i++) begin
      disp2();
      @(negedge clk);
      chk("fill_id0", disp_id[4:0], 2 * i);
      chk("fill_id1", disp_id[9:5], 2 * i + 1);
      tick();
    end
    idle();
    @(negedge clk);
    chk("fill_occ", occupancy, 32);
    chk("fill_ready", disp_ready, 0);
    tick();
    flush = 1; @(negedge clk); tick(); idle();

    disp2(); @(negedge clk); tick();
    disp2(); @(negedge clk); tick();
    idle(); wb(0, 3, 0); wb(1, 2, 0); wb(2, 1, 0);
    @(negedge clk); tick();
    idle(); wb(0, 0, 0);
    @(negedge clk);
    chk("ooo_none", commit_valid, 0);
    tick();
    idle();
    @(negedge clk);
    chk("ooo_cv1", commit_valid, 3);
    chk("ooo_id0", commit_id[4:0], 0);
    chk("ooo_id1", commit_id[9:5], 1);
    tick();
    @(negedge clk);
    chk("ooo_cv2", commit_valid, 3);
    chk("ooo_id2", commit_id[4:0], 2);
    chk("ooo_id3", commit_id[9:5], 3);
    tick();

    flush = 1; @(negedge clk); tick();
    repeat (3) begin disp2(); @(negedge clk); tick(); end
    idle(); wb(0, 0, 0); wb(1, 1, 0); wb(2, 2, 1); wb(3, 3, 0);
    @(negedge clk); tick();
    idle(); wb(0, 4, 0); wb(1, 5, 0);
    @(negedge clk);
    chk("mp_cv1", commit_valid, 3);
    chk("mp_id0", commit_id[4:0], 0);
    chk("mp_id1", commit_id[9:5], 1);
    chk("mp_rd1", redirect, 0);
    tick();
    idle();
    @(negedge clk);
    chk("mp_cv2", commit_valid, 1);
    chk("mp_id2", commit_id[4:0], 2);
    chk("mp_cm2", commit_mispredict[0], 1);
    chk("mp_rd2", redirect, 1);
    tick();
    @(negedge clk);
    chk("mp_occ", occupancy, 0);
    chk("mp_tail", disp_id[4:0], 3);
    tick();

    repeat (5) begin disp2(); @(negedge clk); tick(); end
    idle(); wb(0, 3, 0); wb(1, 4, 0);
    @(negedge clk);
    chk("sim_occ0", occupancy, 10);
    tick();
    disp2();
    @(negedge clk);
    chk("sim_cv", commit_valid, 3);
    tick();
    idle();
    @(negedge clk);
    chk("sim_occ1", occupancy, 10);
    tick();
    disp2(); flush = 1;
    @(negedge clk); tick();
    idle();
    @(negedge clk);
    chk("flush_occ", occupancy, 0);
    chk("flush_empty", empty, 1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      idle();
      disp_valid = 2'($urandom % 4);
      if ($urandom % 4 == 0) disp_valid = 2'b11;
      for (int p = 0; p < 4; p++) begin
        if ($urandom % 3 != 0) begin
          if (rob.size() > 0 && $urandom % 8 != 0)
            wb(p, rob[$urandom % rob.size()].id, ($urandom % 16) == 0);
          else
            wb(p, $urandom % NE, ($urandom % 16) == 0);
        end
      end
      flush = ($urandom % 64) == 0;
      if (i == 1500) begin
        #2 rst = 1;
        #1;
        chk("midrst_occ", occupancy, 0);
        chk("midrst_cv", commit_valid, 0);
        @(negedge clk);
        tick();
        rst = 0;
        idle();
      end
      @(negedge clk);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_mw.md
REORDER_BUFFER_MW -- requirements
Module: reorder_buffer_mw

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_ENTRY, 32, entry count; power of 2, at least 4.
- DISPATCH_W, 2, dispatch lanes per cycle.
- COMMIT_W, 2, commit lanes per cycle.
- WB_PORTS, 4, writeback ports.
- PAYLOAD_W, 64, opaque per-entry payload width (rd_arch, phy regs, opcode, store_id, pc).
- IDX_W, $clog2(NUM_ENTRY), derived; not overridden.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- flush, in, 1, synchronous full flush.
- disp_valid, in, DISPATCH_W, per-lane dispatch request.
- disp_payload, in, DISPATCH_W*PAYLOAD_W, per-lane payload.
- disp_ready, out, 1, ROB can accept a full dispatch group.
- disp_id, out, DISPATCH_W*IDX_W, allocated entry index per lane.
- wb_valid, in, WB_PORTS, writeback strobe.
- wb_id, in, WB_PORTS*IDX_W, completed entry index.
- wb_mispredict, in, WB_PORTS, completing entry mispredicted.
- commit_valid, out, COMMIT_W, per-lane retire.
- commit_payload, out, COMMIT_W*PAYLOAD_W, retiring payloads.
- commit_id, out, COMMIT_W*IDX_W, retiring indices.
- commit_mispredict, out, COMMIT_W, retiring entry mispredicted.
- redirect, out, 1, mispredicted entry retiring this cycle.
- occupancy, out, IDX_W+1, valid entry count.
- empty, out, 1, occupancy == 0.

Function
REQ-003 head and tail SHALL be IDX_W+1-bit pointers; entry index = low IDX_W bits; occupancy = tail - head modulo 2^(IDX_W+1); wrap is natural overflow.
REQ-004 disp_ready SHALL be 1 when (NUM_ENTRY - occupancy) >= DISPATCH_W, computed combinationally from registered state only.
REQ-005 Dispatch lanes SHALL be contiguous: lane k accepted only if disp_valid[0..k] are all 1; lanes above the first 0 are ignored.
REQ-006 disp_id lane k SHALL equal tail+k (low IDX_W bits), combinationally, independent of disp_valid.
REQ-007 When disp_ready and n accepted lanes > 0, the clock edge SHALL write payloads to entries tail..tail+n-1, clear their done/mispredict bits, and set tail <= tail+n.
REQ-008 Each wb_valid port SHALL set done[wb_id] and write mispredict[wb_id] <= wb_mispredict on the edge; multiple ports to one id in one cycle OR their mispredict bits.
REQ-009 Writeback latency to commit SHALL be one cycle: an entry written back at edge N may commit in the cycle after edge N.
REQ-010 commit_valid[k] SHALL be 1 iff k < occupancy, done[head+k]=1, commit_valid[0..k-1] all 1, and commit_mispredict[0..k-1] all 0.
REQ-011 commit_payload, commit_id, commit_mispredict lane k SHALL reflect entry head+k; they are don't-care when commit_valid[k]=0.
REQ-012 redirect SHALL be 1 in any cycle where some commit_valid[k]=1 with commit_mispredict[k]=1; at most one such lane commits per cycle.
REQ-013 On a non-redirect edge with c committing lanes, head <= head+c and done of retired entries SHALL clear.
REQ-014 On a redirect edge, head and tail SHALL both become head+c (c includes the mispredicting lane), all done bits clear, and any same-cycle dispatch is discarded.
REQ-015 Dispatch and non-redirect commit in one cycle SHALL both apply: occupancy' = occupancy + n - c.
REQ-016 flush SHALL take priority over dispatch, writeback, commit and redirect: head <= 0, tail <= 0, all done/mispredict clear; commit_valid and redirect still reflect pre-edge state combinationally.
REQ-017 Writeback to an index outside [head, tail) SHALL be ignored.
REQ-018 Payload storage SHALL not be reset; only pointers and done/mispredict bits.

Reset
REQ-019 rst SHALL asynchronously set head=tail=0 and clear all done/mispredict; after reset: occupancy=0, empty=1, disp_ready=1, commit_valid=0, redirect=0.
REQ-020 rst asserted mid-operation SHALL discard all entries with no commit_valid on release.

Verification
REQ-021 Fill: dispatch 16 pairs with no writeback -> occupancy=32, disp_ready=0; ids 0..31 issued in order.
REQ-022 Wrap: dispatch, complete and commit 40 entries two per cycle -> commit_id sequence 0..31,0..7; occupancy returns to 0.
REQ-023 Out-of-order completion: dispatch ids 0..3, writeback 3,2,1 -> no commit; writeback 0 -> next cycle commit_valid=2'b11 ids 0,1, following cycle ids 2,3.
REQ-024 Mispredict: ids 0..5 valid, all done, id 2 mispredict -> cycle 1 commits 0,1; cycle 2 commits 2 with redirect=1; after edge occupancy=0, head=tail=3.
REQ-025 Simultaneous: occupancy=10, dispatch 2 and commit 2 same cycle -> occupancy stays 10; flush concurrent with dispatch -> occupancy=0, empty=1.
